// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame receiver.
// The line levels and default width are kept here so the checker side can share them.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_LVL      = 1'b0;
  localparam logic STOP_LVL       = 1'b1;
  localparam int   DEFAULT_DATA_W = 4;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Bundle of the line-side inputs and frame-side outputs of parity_frame_rx.
// The master is the upstream line plus downstream consumer; the slave is the receiver.
interface parity_frame_rx_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              bit_en;
  logic              rx;
  logic [DATA_W-1:0] data_out;
  logic              pbit_out;
  logic              frame_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output bit_en, rx,
    input  data_out, pbit_out, frame_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, rx,
    output data_out, pbit_out, frame_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/parity_frame_rx.sv
// Deserialises start/data(LSB first)/parity/stop frames sampled on bit_en ticks and
// presents the last good frame with a registered valid strobe plus parity/framing flags.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_frame_rx_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0]   shift_q,  shift_d;
  logic                pbit_q,   pbit_d;
  logic [DATA_W-1:0]   dataOut_q, dataOut_d;
  logic                pbitOut_q, pbitOut_d;
  logic                valid_q,  valid_d;
  logic                parErr_q, parErr_d;
  logic                frmErr_q, frmErr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      dataOut_q <= '0;
      pbitOut_q <= 1'b0;
      valid_q   <= 1'b0;
      parErr_q  <= 1'b0;
      frmErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      pbit_q    <= pbit_d;
      dataOut_q <= dataOut_d;
      pbitOut_q <= pbitOut_d;
      valid_q   <= valid_d;
      parErr_q  <= parErr_d;
      frmErr_q  <= frmErr_d;
    end
  end

  // Strobes default low so each pulse lasts exactly one clock, even if bit_en stays high.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    pbit_d    = pbit_q;
    dataOut_d = dataOut_q;
    pbitOut_d = pbitOut_q;
    valid_d   = 1'b0;
    parErr_d  = 1'b0;
    frmErr_d  = 1'b0;

    if (bus.bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx == START_LVL) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bitCnt_q] = bus.rx;
          if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = PARITY;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          pbit_d  = bus.rx;
          state_d = STOP;
        end
        STOP: begin
          if (bus.rx == STOP_LVL) begin
            dataOut_d = shift_q;
            pbitOut_d = pbit_q;
            parErr_d  = (^shift_q) ^ pbit_q;
            valid_d   = 1'b1;
          end else begin
            frmErr_d  = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.data_out    = dataOut_q;
  assign bus.pbit_out    = pbitOut_q;
  assign bus.frame_valid = valid_q;
  assign bus.parity_err  = parErr_q;
  assign bus.frame_err   = frmErr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: a table of whole frames plus hand-written
// sequences for reset, restart after a framing error and back-to-back frames.
module tb_parity_frame_rx;
  import parity_pkg::*;

  localparam int DATA_W = 4;

  logic clk;
  logic rst_n;

  parity_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  parity_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int validCnt = 0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) validCnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              pbit;
    logic              stop;
    logic              expValid;
    logic              expPerr;
    logic              expFerr;
    logic [DATA_W-1:0] expData;
    logic              expPbit;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A negative gap draws a random number of idle clocks before the bit_en tick.
  task automatic sendBit(input logic b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 5)) : gap;
    repeat (g) begin
      @(negedge clk);
      bus.bit_en = 1'b0;
    end
    @(negedge clk);
    bus.rx     = b;
    bus.bit_en = 1'b1;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic pbit, input logic stop,
                               input bit doStart, input int startGap, input int gap, input int midGap);
    if (doStart) sendBit(START_LVL, startGap);
    for (int i = 0; i < DATA_W; i++) sendBit(data[i], (i == 2) ? midGap : gap);
    checkOutput("busyMidFrame", {7'd0, bus.busy}, 8'd1);
    sendBit(pbit, gap);
    sendBit(stop, gap);
    @(negedge clk);
    bus.bit_en = 1'b0;
    bus.rx     = 1'b1;
  endtask

  task automatic expectFrame(input string tag, input logic v, input logic pe, input logic fe,
                             input logic [DATA_W-1:0] d, input logic p);
    checkOutput({tag, ".frame_valid"}, {7'd0, bus.frame_valid}, {7'd0, v});
    checkOutput({tag, ".parity_err"},  {7'd0, bus.parity_err},  {7'd0, pe});
    checkOutput({tag, ".frame_err"},   {7'd0, bus.frame_err},   {7'd0, fe});
    checkOutput({tag, ".data_out"},    {4'd0, bus.data_out},    {4'd0, d});
    checkOutput({tag, ".pbit_out"},    {7'd0, bus.pbit_out},    {7'd0, p});
    checkOutput({tag, ".busy"},        {7'd0, bus.busy},        8'd0);
    @(negedge clk);
    checkOutput({tag, ".validDrop"},   {7'd0, bus.frame_valid}, 8'd0);
    checkOutput({tag, ".ferrDrop"},    {7'd0, bus.frame_err},   8'd0);
    checkOutput({tag, ".perrDrop"},    {7'd0, bus.parity_err},  8'd0);
  endtask

  initial begin
    int base;

    vecs[0] = '{4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0};
    vecs[1] = '{4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h7, 1'b0};
    vecs[2] = '{4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 1'b1};
    vecs[3] = '{4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0};
    vecs[4] = '{4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0};

    // Reset held with the line toggling and bit_en high.
    rst_n      = 1'b0;
    bus.bit_en = 1'b1;
    bus.rx     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rx = ~bus.rx;
    end
    checkOutput("rst.data_out",    {4'd0, bus.data_out},    8'd0);
    checkOutput("rst.pbit_out",    {7'd0, bus.pbit_out},    8'd0);
    checkOutput("rst.frame_valid", {7'd0, bus.frame_valid}, 8'd0);
    checkOutput("rst.parity_err",  {7'd0, bus.parity_err},  8'd0);
    checkOutput("rst.frame_err",   {7'd0, bus.frame_err},   8'd0);
    checkOutput("rst.busy",        {7'd0, bus.busy},        8'd0);
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("postRst.noStrobe", validCnt[7:0], 8'd0);
    checkOutput("postRst.busy",     {7'd0, bus.busy}, 8'd0);

    // Table of whole frames, bit_en every 4 clocks.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k].data, vecs[k].pbit, vecs[k].stop, 1'b1, 3, 3, 3);
      expectFrame($sformatf("vec%0d", k), vecs[k].expValid, vecs[k].expPerr, vecs[k].expFerr,
                  vecs[k].expData, vecs[k].expPbit);
    end

    // Line still low after the bad stop bit: the very next tick is taken as a start bit.
    sendBit(1'b0, 0);
    @(negedge clk);
    bus.bit_en = 1'b0;
    checkOutput("restart.busy", {7'd0, bus.busy}, 8'd1);
    applyStimulus(4'h6, 1'b0, 1'b1, 1'b0, 0, 3, 3);
    expectFrame("restart", 1'b1, 1'b0, 1'b0, 4'h6, 1'b0);

    // Reset after two data bits aborts the frame immediately.
    sendBit(1'b0, 3);
    sendBit(1'b1, 3);
    sendBit(1'b0, 3);
    @(negedge clk);
    bus.bit_en = 1'b0;
    checkOutput("midRst.busyBefore", {7'd0, bus.busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.busy",     {7'd0, bus.busy},     8'd0);
    checkOutput("midRst.data_out", {4'd0, bus.data_out}, 8'd0);
    checkOutput("midRst.pbit_out", {7'd0, bus.pbit_out}, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = validCnt;
    sendBit(1'b1, 1);
    @(negedge clk);
    bus.bit_en = 1'b0;
    checkOutput("midRst.idleAfter", {7'd0, bus.busy}, 8'd0);
    applyStimulus(4'h5, 1'b0, 1'b1, 1'b1, 3, 3, 3);
    expectFrame("afterRst", 1'b1, 1'b0, 1'b0, 4'h5, 1'b0);
    checkOutput("afterRst.pulses", 8'(validCnt - base), 8'd1);

    // Back-to-back frames with random gaps and a long pause mid-frame.
    base = validCnt;
    applyStimulus(4'hF, 1'b0, 1'b1, 1'b1, -1, -1, 10);
    expectFrame("b2b0", 1'b1, 1'b0, 1'b0, 4'hF, 1'b0);
    applyStimulus(4'h1, 1'b1, 1'b1, 1'b1, 0, -1, 10);
    expectFrame("b2b1", 1'b1, 1'b0, 1'b0, 4'h1, 1'b1);
    checkOutput("b2b.pulses", 8'(validCnt - base), 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
